apb_transfer_sequencer: RTL and testbench

- Sequences the APB-side datapath of the AHB2APB bridge: accepts decoded transfer requests from the AHB slave side, buffers up to two, and drives the APB interface through the IDLE -> SETUP -> ACCESS protocol.
- Performs slave select decode, inserts programmable wait states, captures Prdata, and returns one response per request.
- Sits between the AHB slave interface and the APB interface block.

---
 rtl/apb_transfer_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_apb_transfer_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_transfer_sequencer.sv
// APB transfer sequencer: buffers up to two decoded requests and walks the
// head entry through the APB IDLE -> SETUP -> ACCESS protocol, returning one
// registered response pulse per request.
module apb_transfer_sequencer #(
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned FIFO_DEPTH  = 2
) (
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        Pwrite,
   output logic [2:0]  Pselx,
   output logic        Penable,
   output logic [31:0] Paddr,
   output logic [31:0] Pwdata,
   input  logic [31:0] Prdata
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS
   } state_e;

   typedef struct packed {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   state_e      state_q, state_d;
   req_t        fifo0_q, fifo0_d;
   req_t        fifo1_q, fifo1_d;
   logic [1:0]  count_q, count_d;
   logic [3:0]  wait_q, wait_d;
   logic        pwrite_q, pwrite_d;
   logic [2:0]  pselx_q, pselx_d;
   logic        penable_q, penable_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;

   logic        full;
   logic        push;
   logic        pop;
   logic [1:0]  wr_idx;
   logic [2:0]  head_sel;
   logic [2:0]  next_sel;
   req_t        new_req;

   // Three 64 MB windows starting at 0x8000_0000; zero means decode error.
   function automatic logic [2:0] decode(input logic [31:0] addr);
      case (addr[31:26])
         6'h20:   decode = 3'b001;
         6'h21:   decode = 3'b010;
         6'h22:   decode = 3'b100;
         default: decode = 3'b000;
      endcase
   endfunction

   assign full      = (count_q == 2'(FIFO_DEPTH));
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign head_sel  = decode(fifo0_q.addr);
   assign next_sel  = decode(fifo1_q.addr);
   assign new_req   = '{write: req_write, addr: req_addr, wdata: req_wdata};

   // Protocol FSM: next state, APB drive values and response for next cycle.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      pop         = 1'b0;
      pwrite_d    = pwrite_q;
      pselx_d     = pselx_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      case (state_q)
         ST_IDLE: begin
            pselx_d   = '0;
            penable_d = 1'b0;
            if (count_q != 2'd0) begin
               if (head_sel != 3'b000) begin
                  state_d  = ST_SETUP;
                  pselx_d  = head_sel;
                  paddr_d  = fifo0_q.addr;
                  pwrite_d = fifo0_q.write;
                  pwdata_d = fifo0_q.wdata;
               end else begin
                  pop         = 1'b1;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end
            end
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
            wait_d    = 4'(WAIT_STATES);
         end
         ST_ACCESS: begin
            if (wait_q != 4'd0) begin
               wait_d = wait_q - 4'd1;
            end else begin
               pop         = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : Prdata;
               penable_d   = 1'b0;
               // Only an already-stored second entry chains straight into
               // SETUP; an erroring one is left for IDLE to report.
               if (count_q == 2'd2 && next_sel != 3'b000) begin
                  state_d  = ST_SETUP;
                  pselx_d  = next_sel;
                  paddr_d  = fifo1_q.addr;
                  pwrite_d = fifo1_q.write;
                  pwdata_d = fifo1_q.wdata;
               end else begin
                  state_d = ST_IDLE;
                  pselx_d = '0;
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            pselx_d   = '0;
            penable_d = 1'b0;
         end
      endcase
   end

   // Two-entry request buffer; a push lands behind whatever survives the pop.
   always_comb begin
      fifo0_d = fifo0_q;
      fifo1_d = fifo1_q;
      wr_idx  = count_q - {1'b0, pop};
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
         fifo0_d = fifo1_q;
      end
      if (push) begin
         if (wr_idx == 2'd0) begin
            fifo0_d = new_req;
         end else begin
            fifo1_d = new_req;
         end
      end
   end

   // State, buffer and registered outputs; reset clears everything at once.
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state_q     <= ST_IDLE;
         fifo0_q     <= '0;
         fifo1_q     <= '0;
         count_q     <= '0;
         wait_q      <= '0;
         pwrite_q    <= 1'b0;
         pselx_q     <= '0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         fifo0_q     <= fifo0_d;
         fifo1_q     <= fifo1_d;
         count_q     <= count_d;
         wait_q      <= wait_d;
         pwrite_q    <= pwrite_d;
         pselx_q     <= pselx_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign Pwrite    = pwrite_q;
   assign Pselx     = pselx_q;
   assign Penable   = penable_q;
   assign Paddr     = paddr_q;
   assign Pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_transfer_sequencer.sv
// Directed bench for apb_transfer_sequencer: one instance with no wait
// states and one with three, sharing stimulus.
module tb_apb_transfer_sequencer;

   logic        Hclk;
   logic        Hresetn;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] Prdata;

   logic        ready0, rv0, rerr0, pw0, pen0;
   logic [31:0] rdat0, pa0, pwd0;
   logic [2:0]  psel0;
   logic        ready3, rv3, rerr3, pw3, pen3;
   logic [31:0] rdat3, pa3, pwd3;
   logic [2:0]  psel3;

   int unsigned n_vec;
   int unsigned n_err;

   apb_transfer_sequencer #(.WAIT_STATES(0), .FIFO_DEPTH(2)) u_dut0 (
      .Hclk(Hclk), .Hresetn(Hresetn),
      .req_valid(req_valid), .req_ready(ready0), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv0), .rsp_err(rerr0), .rsp_rdata(rdat0),
      .Pwrite(pw0), .Pselx(psel0), .Penable(pen0), .Paddr(pa0),
      .Pwdata(pwd0), .Prdata(Prdata)
   );

   apb_transfer_sequencer #(.WAIT_STATES(3), .FIFO_DEPTH(2)) u_dut3 (
      .Hclk(Hclk), .Hresetn(Hresetn),
      .req_valid(req_valid), .req_ready(ready3), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv3), .rsp_err(rerr3), .rsp_rdata(rdat3),
      .Pwrite(pw3), .Pselx(psel3), .Penable(pen3), .Paddr(pa3),
      .Pwdata(pwd3), .Prdata(Prdata)
   );

   initial Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Hclk);
      #1;
   endtask

   task automatic do_reset();
      Hresetn   = 1'b0;
      req_valid = 1'b0;
      tick();
      Hresetn = 1'b1;
   endtask

   task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec     = 0;
      n_err     = 0;
      Hresetn   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      Prdata    = 32'h0000_1234;
      tick();
      tick();
      check("rst_ready", ready0, 1);
      check("rst_psel", psel0, 0);
      check("rst_pen", pen0, 0);
      check("rst_rspv", rv0, 0);
      check("rst_paddr", pa0, 0);
      Hresetn = 1'b1;
      tick();

      // single write, no wait states
      drive(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
      tick();
      req_valid = 1'b0;
      check("w_n1_psel", psel0, 0);
      tick();
      check("w_setup_psel", psel0, 3'b001);
      check("w_setup_pen", pen0, 0);
      check("w_setup_paddr", pa0, 32'h8000_0010);
      check("w_setup_pwdata", pwd0, 32'hDEAD_BEEF);
      check("w_setup_pwrite", pw0, 1);
      tick();
      check("w_access_pen", pen0, 1);
      check("w_access_psel", psel0, 3'b001);
      check("w_access_rspv", rv0, 0);
      tick();
      check("w_rsp_valid", rv0, 1);
      check("w_rsp_err", rerr0, 0);
      check("w_rsp_rdata", rdat0, 0);
      check("w_idle_pen", pen0, 0);
      check("w_idle_psel", psel0, 0);
      tick();
      check("w_rsp_pulse", rv0, 0);
      do_reset();

      // single read from third slave
      Prdata = 32'h0000_00A5;
      drive(1'b0, 32'h8800_0004, 32'h0);
      tick();
      req_valid = 1'b0;
      tick();
      check("r_setup_psel", psel0, 3'b100);
      check("r_setup_pwrite", pw0, 0);
      check("r_setup_paddr", pa0, 32'h8800_0004);
      tick();
      check("r_access_pen", pen0, 1);
      tick();
      check("r_rsp_valid", rv0, 1);
      check("r_rsp_err", rerr0, 0);
      check("r_rsp_rdata", rdat0, 32'h0000_00A5);
      do_reset();

      // three back-to-back requests held on req_valid
      Prdata = 32'h5A5A_0001;
      drive(1'b1, 32'h8000_0000, 32'h1111_1111);
      check("b_c0_ready", ready0, 1);
      tick();
      drive(1'b0, 32'h8400_0000, 32'h0);
      check("b_c1_ready", ready0, 1);
      check("b_c1_psel", psel0, 0);
      tick();
      drive(1'b1, 32'h8800_0000, 32'h3333_3333);
      check("b_c2_ready", ready0, 0);
      check("b_c2_psel", psel0, 3'b001);
      check("b_c2_pen", pen0, 0);
      tick();
      check("b_c3_ready", ready0, 0);
      check("b_c3_pen", pen0, 1);
      check("b_c3_psel", psel0, 3'b001);
      tick();
      check("b_c4_ready", ready0, 1);
      check("b_c4_psel", psel0, 3'b010);
      check("b_c4_pen", pen0, 0);
      check("b_c4_rspv", rv0, 1);
      check("b_c4_rdata", rdat0, 0);
      tick();
      req_valid = 1'b0;
      check("b_c5_pen", pen0, 1);
      check("b_c5_psel", psel0, 3'b010);
      check("b_c5_rspv", rv0, 0);
      tick();
      check("b_c6_psel", psel0, 3'b100);
      check("b_c6_pen", pen0, 0);
      check("b_c6_rspv", rv0, 1);
      check("b_c6_rdata", rdat0, 32'h5A5A_0001);
      check("b_c6_pwdata", pwd0, 32'h3333_3333);
      tick();
      check("b_c7_pen", pen0, 1);
      check("b_c7_rspv", rv0, 0);
      tick();
      check("b_c8_rspv", rv0, 1);
      check("b_c8_rdata", rdat0, 0);
      check("b_c8_psel", psel0, 0);
      check("b_c8_pen", pen0, 0);
      check("b_c8_ready", ready0, 1);
      do_reset();

      // decode error
      drive(1'b1, 32'h9000_0000, 32'hCAFE_0000);
      tick();
      req_valid = 1'b0;
      check("e_n1_psel", psel0, 0);
      check("e_n1_rspv", rv0, 0);
      tick();
      check("e_rsp_valid", rv0, 1);
      check("e_rsp_err", rerr0, 1);
      check("e_rsp_rdata", rdat0, 0);
      check("e_psel", psel0, 0);
      check("e_pen", pen0, 0);
      tick();
      check("e_rsp_pulse", rv0, 0);
      check("e_after_psel", psel0, 0);
      do_reset();

      // three wait states, read from second slave
      Prdata = 32'h0000_C0DE;
      drive(1'b0, 32'h8400_0008, 32'h0);
      tick();
      req_valid = 1'b0;
      tick();
      check("ws_setup_psel", psel3, 3'b010);
      check("ws_setup_pen", pen3, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("ws_access%0d_pen", i), pen3, 1);
         check($sformatf("ws_access%0d_paddr", i), pa3, 32'h8400_0008);
         check($sformatf("ws_access%0d_rspv", i), rv3, 0);
      end
      tick();
      check("ws_rsp_valid", rv3, 1);
      check("ws_rsp_rdata", rdat3, 32'h0000_C0DE);
      check("ws_rsp_err", rerr3, 0);
      check("ws_idle_pen", pen3, 0);
      tick();
      check("ws_rsp_pulse", rv3, 0);
      do_reset();

      // reset during ACCESS with a second entry queued
      drive(1'b1, 32'h8000_0020, 32'h0BAD_F00D);
      tick();
      drive(1'b0, 32'h8400_0000, 32'h0);
      tick();
      req_valid = 1'b0;
      check("rr_setup_psel", psel0, 3'b001);
      tick();
      check("rr_access_pen", pen0, 1);
      #2;
      Hresetn = 1'b0;
      #1;
      check("rr_async_pen", pen0, 0);
      check("rr_async_psel", psel0, 0);
      check("rr_async_paddr", pa0, 0);
      check("rr_async_ready", ready0, 1);
      @(posedge Hclk);
      #1;
      Hresetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("rr_post%0d_rspv", i), rv0, 0);
         check($sformatf("rr_post%0d_psel", i), psel0, 0);
         check($sformatf("rr_post%0d_ready", i), ready0, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
